muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  HI/LO multiply-divide unit fed by the register file read ports (a<-rd1, b<-rd2).
//  Executes MULT/MULTU/DIV/DIVU as multi-cycle operations, holds HI/LO and supports MTHI/MTLO.
//  Raises busy so the controller stalls MFHI/MFLO and any new mul/div until the result commits.
// PARAMETERS
//  WIDTH        32  operand width; HI and LO are each WIDTH bits
//  MULT_CYCLES  5   busy cycles for a multiply (>=1)
//  DIV_CYCLES   10  busy cycles for a divide (>=1)
// PORTS
//  clk    in   1      rising-edge clock
//  rst_n  in   1      asynchronous, active-low reset
//  start  in   1      launch op with a, b; sampled on clk edge
//  op     in   3      operation code, encodings in muldiv_pkg
//  a      in   WIDTH  operand A (rd1)
//  b      in   WIDTH  operand B (rd2)
//  hi_we  in   1      MTHI: write wd to HI
//  lo_we  in   1      MTLO: write wd to LO
//  wd     in   WIDTH  MTHI/MTLO data
//  busy   out  1      operation in flight
//  hi     out  WIDTH  HI register
//  lo     out  WIDTH  LO register
// BEHAVIOUR
//  - Reset (async on rst_n low): busy=0, hi=0, lo=0, counter=0, pending result cleared. Reset mid-op aborts it; nothing commits.
//  - States IDLE/RUN. IDLE & start at edge T -> RUN. Result computed from a/b at T and latched into a pending register.
//    The counter is loaded with N-1, where N=MULT_CYCLES or DIV_CYCLES. busy=1 from T through edge T+N.
//    At edge T+N, hi/lo take the pending result and busy=0, giving a result latency of N cycles.
//  - start while busy: ignored (controller must stall). Unrecognised op with start: ignored, stays IDLE.
//  - hi_we/lo_we honoured only in IDLE without start. When start and a write coincide, start wins and the write is dropped.
//    hi_we and lo_we together: both written with wd.
//  - MULT: {hi,lo} = signed a*b (2*WIDTH). MULTU: unsigned.
//  - DIV: lo=quotient truncated toward zero, hi=remainder with the sign of the dividend. DIVU: unsigned.
//  - Divide by zero (b==0): lo=all-ones, hi=a. Takes DIV_CYCLES cycles like any divide.
//  - Signed overflow (a=min, b=-1): lo=min (0x80000000), hi=0.
//  - hi/lo are stable during RUN. Old values remain readable but the controller must not consume them.
// CONFIGURATION
//  MULDIV_MADD_EN defined: adds MADD/MADDU/MSUB/MSUBU with MULT_CYCLES latency.
//    These compute {hi,lo} +/- product, using the HI/LO values sampled at start and wrapping modulo 2^(2*WIDTH).
//  MULDIV_MADD_EN undefined: those op codes are treated as unrecognised (ignored).
// STRUCTURE
//  muldiv_pkg: op code localparams (MULT=0, MULTU=1, DIV=2, DIVU=3, MADD=4, MADDU=5, MSUB=6, MSUBU=7) and the IDLE/RUN state encoding.
//  Sub-module muldiv_core: combinational {hi,lo} result from op, a, b, hi, lo, including the zero and overflow rules.
//  muldiv_unit: FSM, counter, pending register, HI/LO registers and write-port priority.
// TESTING
//  1. Reset, then MULT a=-3 (0xFFFFFFFD), b=7 -> busy high 5 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//  2. MULTU a=0xFFFFFFFF, b=2 -> hi=1, lo=0xFFFFFFFE after 5 cycles.
//  3. DIV a=-7, b=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 -> lo=0xFFFFFFFF, hi=7.
//  4. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
//  5. hi_we with wd=0x1234 in IDLE -> hi=0x1234 next edge. Then:
//     - hi_we together with start -> hi takes the op result, not wd.
//     - start during busy -> ignored, original result commits unchanged.
//  6. Drop rst_n at cycle 3 of a DIV -> busy=0, hi=lo=0 immediately, no later commit.
//     With MULDIV_MADD_EN: hi=0, lo=5, MADD 2*3 -> lo=11.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM state encoding and op classification for the HI/LO multiply-divide unit.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MADDU = 3'd5;
  localparam logic [2:0] OP_MSUB  = 3'd6;
  localparam logic [2:0] OP_MSUBU = 3'd7;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Register-file side bus of the multiply-divide unit: launch, MTHI/MTLO writes, HI/LO readback.
interface muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wd;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, hi_we, lo_we, wd, input busy, hi, lo);
  modport slave  (input start, op, a, b, hi_we, lo_we, wd, output busy, hi, lo);
endinterface

// File: rtl/muldiv_core.sv
// Combinational {hi,lo} result for every op code, including divide-by-zero and signed overflow.
// MADD/MADDU/MSUB/MSUBU are flagged valid only when MULDIV_MADD_EN is defined.
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  localparam int W2 = 2 * WIDTH;

  logic [W2-1:0]    w_sext_a, w_sext_b, w_zext_a, w_zext_b;
  logic [W2-1:0]    w_sprod, w_uprod, w_acc, w_res;
  logic             w_sdiv, w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_n, w_d, w_d_safe, w_q, w_r, w_q_fix, w_r_fix;

  assign w_sext_a = {{WIDTH{i_a[WIDTH-1]}}, i_a};
  assign w_sext_b = {{WIDTH{i_b[WIDTH-1]}}, i_b};
  assign w_zext_a = {{WIDTH{1'b0}}, i_a};
  assign w_zext_b = {{WIDTH{1'b0}}, i_b};
  assign w_sprod  = w_sext_a * w_sext_b;
  assign w_uprod  = w_zext_a * w_zext_b;
  assign w_acc    = {i_hi, i_lo};

  // Signed divide runs on magnitudes; min/-1 falls out as |min|/1 = min with remainder 0.
  assign w_sdiv   = (i_op == OP_DIV);
  assign w_a_neg  = w_sdiv & i_a[WIDTH-1];
  assign w_b_neg  = w_sdiv & i_b[WIDTH-1];
  assign w_n      = w_a_neg ? -i_a : i_a;
  assign w_d      = w_b_neg ? -i_b : i_b;
  assign w_d_safe = (i_b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : w_d;
  assign w_q      = w_n / w_d_safe;
  assign w_r      = w_n % w_d_safe;
  assign w_q_fix  = (w_a_neg ^ w_b_neg) ? -w_q : w_q;
  assign w_r_fix  = w_a_neg ? -w_r : w_r;

  always_comb begin
    w_res   = w_acc;
    o_valid = 1'b1;
    case (i_op)
      OP_MULT:  w_res = w_sprod;
      OP_MULTU: w_res = w_uprod;
      OP_DIV, OP_DIVU:
        w_res = (i_b == '0) ? {i_a, {WIDTH{1'b1}}} : {w_r_fix, w_q_fix};
      OP_MADD:  w_res = w_acc + w_sprod;
      OP_MADDU: w_res = w_acc + w_uprod;
      OP_MSUB:  w_res = w_acc - w_sprod;
      OP_MSUBU: w_res = w_acc - w_uprod;
      default:  w_res = w_acc;
    endcase
`ifdef MULDIV_MADD_EN
    o_valid = 1'b1;
`else
    o_valid = ~i_op[2];
`endif
  end

  assign o_hi = w_res[W2-1:WIDTH];
  assign o_lo = w_res[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply-divide unit: launch FSM, latency down-counter, pending result and HI/LO registers.
// Optional MULDIV_MADD_EN enables the MADD/MADDU/MSUB/MSUBU op codes (handled in muldiv_core).
//
// state | meaning
// IDLE  | HI/LO writable, accepts start with a recognised op
// RUN   | result pending, counter runs down to 0, then HI/LO commit
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;

  logic [0:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_pend_hi, r_pend_lo, r_hi, r_lo;
  logic             w_valid;
  logic [WIDTH-1:0] w_res_hi, w_res_lo;
  logic [CW-1:0]    w_load;

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .i_op    (bus.op),
    .i_a     (bus.a),
    .i_b     (bus.b),
    .i_hi    (r_hi),
    .i_lo    (r_lo),
    .o_valid (w_valid),
    .o_hi    (w_res_hi),
    .o_lo    (w_res_lo)
  );

  assign w_load = is_div_op(bus.op) ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // start outranks MTHI/MTLO even when its op is unrecognised
          if (bus.start) begin
            if (w_valid) begin
              r_state   <= ST_RUN;
              r_pend_hi <= w_res_hi;
              r_pend_lo <= w_res_lo;
              r_cnt     <= w_load;
            end
          end else begin
            if (bus.hi_we) r_hi <= bus.wd;
            if (bus.lo_we) r_lo <= bus.wd;
          end
        end
        ST_RUN: begin
          if (r_cnt == '0) begin
            r_hi    <= r_pend_hi;
            r_lo    <= r_pend_lo;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = (r_state == ST_RUN);
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, corner sequences, random ops vs reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [31:0] m_hi, m_lo;

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int op_cycles(input logic [2:0] op);
    return (op == OP_DIV || op == OP_DIVU) ? DC : MC;
  endfunction

  // Reference: straight arithmetic on wide integers, plus the divide corner rules.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi,
                                        input logic [31:0] lo);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, acc;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    acc = {hi, lo};
    q   = 0;
    r   = 0;
    case (op)
      OP_MULT:  return 64'(sa * sb);
      OP_MULTU: return ua * ub;
      OP_DIV: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      OP_DIVU: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      OP_MADD:  return acc + 64'(sa * sb);
      OP_MADDU: return acc + ua * ub;
      OP_MSUB:  return acc - 64'(sa * sb);
      default:  return acc - ua * ub;
    endcase
  endfunction

  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (bus.busy && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic run_check(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int cyc;
    logic [31:0] old_hi;
    old_hi = m_hi;
    launch(op, a, b);
    check({name, "_busy"}, {31'h0, bus.busy}, 32'h1);
    check({name, "_hold_hi"}, bus.hi, old_hi);
    wait_idle(cyc);
    check({name, "_cycles"}, cyc, op_cycles(op));
    check({name, "_hi"}, bus.hi, eh);
    check({name, "_lo"}, bus.lo, el);
    m_hi = eh;
    m_lo = el;
  endtask

  task automatic mt_write(input logic hw, input logic lw, input logic [31:0] wd);
    @(negedge clk);
    bus.hi_we = hw;
    bus.lo_we = lw;
    bus.wd    = wd;
    @(posedge clk);
    #1;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    if (hw) m_hi = wd;
    if (lw) m_lo = wd;
    check("mt_hi", bus.hi, m_hi);
    check("mt_lo", bus.lo, m_lo);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[8];
    logic [63:0] r;
    int cyc, c1;
    vt[0] = '{OP_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vt[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE};
    vt[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vt[3] = '{OP_DIVU,  32'd7,         32'd0,        32'h0000_0007, 32'hFFFF_FFFF};
    vt[4] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vt[5] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vt[6] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vt[7] = '{OP_DIV,   32'hFFFF_FFF8, 32'd0,        32'hFFFF_FFF8, 32'hFFFF_FFFF};

    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wd = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'h0, bus.busy}, 32'h0);
    check("rst_hi", bus.hi, 32'h0);
    check("rst_lo", bus.lo, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      run_check($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].exp_hi, vt[i].exp_lo);

    // MTHI alone, then both ports together
    mt_write(1'b1, 1'b0, 32'h0000_1234);
    mt_write(1'b1, 1'b1, 32'h0000_1234);

    // start wins over a coinciding write
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULT; bus.a = 32'd2; bus.b = 32'd3;
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wd = 32'hDEAD;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    check("coinc_drop_hi", bus.hi, 32'h1234);
    check("coinc_drop_lo", bus.lo, 32'h1234);
    wait_idle(cyc);
    check("coinc_cycles", cyc, MC);
    check("coinc_hi", bus.hi, 32'h0);
    check("coinc_lo", bus.lo, 32'd6);

    // start and MTLO while busy are both ignored
    launch(OP_MULTU, 32'd5, 32'd5);
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd100; bus.b = 32'd0;
    bus.lo_we = 1'b1; bus.wd = 32'hBEEF;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.lo_we = 1'b0;
    c1 = 1;
    wait_idle(cyc);
    check("busy_start_cycles", c1 + cyc, MC);
    check("busy_start_hi", bus.hi, 32'h0);
    check("busy_start_lo", bus.lo, 32'd25);
    @(posedge clk);
    #1;
    check("busy_start_no_relaunch", {31'h0, bus.busy}, 32'h0);
    m_hi = 32'h0; m_lo = 32'd25;

`ifdef MULDIV_MADD_EN
    mt_write(1'b1, 1'b0, 32'h0);
    mt_write(1'b0, 1'b1, 32'd5);
    run_check("madd", OP_MADD, 32'd2, 32'd3, 32'h0, 32'd11);
`else
    launch(OP_MADD, 32'd2, 32'd3);
    check("madd_ignored_busy", {31'h0, bus.busy}, 32'h0);
    check("madd_ignored_lo", bus.lo, m_lo);
`endif

    // reset during the third busy cycle of a divide
    launch(OP_DIV, 32'd100, 32'd7);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'h0, bus.busy}, 32'h0);
    check("midrst_hi", bus.hi, 32'h0);
    check("midrst_lo", bus.lo, 32'h0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    c1 = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (bus.busy) c1++;
    end
    check("midrst_no_busy", c1, 0);
    check("midrst_no_commit_hi", bus.hi, 32'h0);
    check("midrst_no_commit_lo", bus.lo, 32'h0);

    // random ops with occasional MTHI/MTLO
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      int pick;
      if ($urandom_range(0, 3) == 0)
        mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
`ifdef MULDIV_MADD_EN
      op = 3'($urandom_range(0, 7));
`else
      op = 3'($urandom_range(0, 3));
`endif
      a = $urandom;
      b = $urandom;
      pick = $urandom_range(0, 7);
      if (pick == 0) b = 32'h0;
      else if (pick == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (pick == 2) b = 32'($urandom_range(1, 16));
      else if (pick == 3) b = -32'($urandom_range(1, 16));
      r = model(op, a, b, m_hi, m_lo);
      run_check($sformatf("rnd%0d_op%0d", i, op), op, a, b, r[63:32], r[31:0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
